arf_err_stats: RTL and testbench

Downstream statistics stage for the ARF datapath. It consumes the two filter outputs (out_27, out_28) of the approximate datapath together with the matching exact-datapath outputs. Over a window of 2^LOG2N accepted samples it accumulates the signed error, and the squared error, of each channel. At the end of the window it reports the per-channel error mean and error variance. The results feed the ILP error-variance characterisation flow.

---
 rtl/arf_err_stats.sv | 99 +++++++++
 tb/tb_arf_err_stats.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/arf_err_stats.sv
// arf_err_stats: windowed per-channel error mean and variance of approx vs exact ARF outputs
module arf_err_stats #(
  parameter int W     = 16,
  parameter int LOG2N = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           approx_27,
  input  logic [W-1:0]           approx_28,
  input  logic [W-1:0]           exact_27,
  input  logic [W-1:0]           exact_28,
  output logic                   busy,
  output logic                   done,
  output logic signed [W:0]      mean_27,
  output logic [2*W+1:0]         var_27,
  output logic signed [W:0]      mean_28,
  output logic [2*W+1:0]         var_28,
  output logic [LOG2N:0]         sample_cnt
);
  localparam int SW = W + 1 + LOG2N;
  localparam int QW = 2*W + 2 + LOG2N;
  localparam logic [LOG2N:0] LAST = (LOG2N+1)'((1 << LOG2N) - 1);
  typedef enum logic [2:0] {IDLE, ACCUM, CALC_MEAN, CALC_VAR27, CALC_VAR28, DONE} state_t;
  state_t state, state_nx;
  logic signed [SW-1:0]   sum_27, sum_28;
  logic [QW-1:0]          sumsq_27, sumsq_28;
  logic [2*W+1:0]         sq_27, sq_28, sq_sel;
  logic signed [W:0]      e_27, e_28, sq_in;
  logic signed [2*W+1:0]  e2_27, e2_28, prod;
  logic [2*W+2:0]         diff;
  logic                   accept;
  assign e_27     = {approx_27[W-1], approx_27} - {exact_27[W-1], exact_27};
  assign e_28     = {approx_28[W-1], approx_28} - {exact_28[W-1], exact_28};
  assign e2_27    = e_27 * e_27;
  assign e2_28    = e_28 * e_28;
  assign in_ready = state == ACCUM;
  assign busy     = state inside {ACCUM, CALC_MEAN, CALC_VAR27, CALC_VAR28};
  assign done     = state == DONE;
  assign accept   = in_valid && in_ready;
  // single squarer shared by the two variance cycles
  assign sq_in    = state == CALC_VAR27 ? mean_27 : mean_28;
  assign sq_sel   = state == CALC_VAR27 ? sq_27 : sq_28;
  assign prod     = sq_in * sq_in;
  assign diff     = {1'b0, sq_sel} - {1'b0, prod};
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       state_nx = start ? ACCUM : IDLE;
      ACCUM:      state_nx = (accept && sample_cnt == LAST) ? CALC_MEAN : ACCUM;
      CALC_MEAN:  state_nx = CALC_VAR27;
      CALC_VAR27: state_nx = CALC_VAR28;
      CALC_VAR28: state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sum_27     <= '0;
      sum_28     <= '0;
      sumsq_27   <= '0;
      sumsq_28   <= '0;
      sample_cnt <= '0;
      sq_27      <= '0;
      sq_28      <= '0;
      mean_27    <= '0;
      mean_28    <= '0;
      var_27     <= '0;
      var_28     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        sum_27     <= '0;
        sum_28     <= '0;
        sumsq_27   <= '0;
        sumsq_28   <= '0;
        sample_cnt <= '0;
      end
      if (accept) begin
        sum_27     <= sum_27 + {{LOG2N{e_27[W]}}, e_27};
        sum_28     <= sum_28 + {{LOG2N{e_28[W]}}, e_28};
        sumsq_27   <= sumsq_27 + {{LOG2N{1'b0}}, e2_27};
        sumsq_28   <= sumsq_28 + {{LOG2N{1'b0}}, e2_28};
        sample_cnt <= sample_cnt + 1'b1;
      end
      if (state == CALC_MEAN) begin
        mean_27 <= (W+1)'(sum_27 >>> LOG2N);
        mean_28 <= (W+1)'(sum_28 >>> LOG2N);
        sq_27   <= (2*W+2)'(sumsq_27 >> LOG2N);
        sq_28   <= (2*W+2)'(sumsq_28 >> LOG2N);
      end
      if (state == CALC_VAR27) var_27 <= diff[2*W+2] ? '0 : diff[2*W+1:0];
      if (state == CALC_VAR28) var_28 <= diff[2*W+2] ? '0 : diff[2*W+1:0];
    end
  end
endmodule

// File: tb/tb_arf_err_stats.sv
// tb_arf_err_stats: directed windows checked against a queue-based statistics model
module tb_arf_err_stats;
  localparam int W = 16;
  localparam int L = 2;
  localparam int N = 4;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [W-1:0] a27 = '0, a28 = '0, x27 = '0, x28 = '0;
  logic in_ready, busy, done;
  logic signed [W:0] mean_27, mean_28;
  logic [2*W+1:0] var_27, var_28;
  logic [L:0] sample_cnt;
  int tests = 0, fails = 0;
  bit chk_en = 0;
  longint q27[$], q28[$];
  bit m_acc = 0;
  int m_post = 0, m_cnt = 0;
  longint r_m27 = 0, r_v27 = 0, r_m28 = 0, r_v28 = 0;

  arf_err_stats #(.W(W), .LOG2N(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .approx_27(a27), .approx_28(a28), .exact_27(x27), .exact_28(x28),
    .busy(busy), .done(done), .mean_27(mean_27), .var_27(var_27),
    .mean_28(mean_28), .var_28(var_28), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint f_mean(input longint q[$]);
    longint s = 0;
    foreach (q[i]) s += q[i];
    return s >= 0 ? s / N : -((-s + N - 1) / N);
  endfunction

  function automatic longint f_var(input longint q[$]);
    longint ss = 0, m, v;
    foreach (q[i]) ss += q[i] * q[i];
    m = f_mean(q);
    v = ss / N - m * m;
    return v < 0 ? 0 : v;
  endfunction

  // model: m_post counts the cycles after the last accept (4 = done cycle)
  always @(posedge clk) begin
    if (!rst_n) begin
      m_acc = 0; m_post = 0; m_cnt = 0;
      r_m27 = 0; r_v27 = 0; r_m28 = 0; r_v28 = 0;
      q27.delete(); q28.delete();
    end else if (m_post == 4) m_post = 0;
    else if (m_post > 0) begin
      m_post++;
      if (m_post == 4) begin
        r_m27 = f_mean(q27); r_v27 = f_var(q27);
        r_m28 = f_mean(q28); r_v28 = f_var(q28);
      end
    end else if (m_acc) begin
      if (in_valid) begin
        q27.push_back(longint'($signed(a27)) - longint'($signed(x27)));
        q28.push_back(longint'($signed(a28)) - longint'($signed(x28)));
        m_cnt++;
        if (m_cnt == N) begin m_acc = 0; m_post = 1; end
      end
    end else if (start) begin
      m_acc = 1; m_cnt = 0; q27.delete(); q28.delete();
    end
    #1;
    if (chk_en) begin
      chk("in_ready", in_ready, m_acc);
      chk("busy", busy, m_acc || (m_post inside {[1:3]}));
      chk("done", done, m_post == 4);
      chk("sample_cnt", sample_cnt, m_cnt);
      if (!(m_post inside {[1:3]})) begin
        chk("mean_27", $signed(mean_27), r_m27);
        chk("var_27", var_27, r_v27);
        chk("mean_28", $signed(mean_28), r_m28);
        chk("var_28", var_28, r_v28);
      end
    end
  end

  task automatic send(input int p27, input int e27, input int p28, input int e28);
    in_valid = 1;
    a27 = W'(p27); x27 = W'(e27); a28 = W'(p28); x28 = W'(e28);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 20) begin @(negedge clk); k++; end
    chk({name, "_latency"}, k, 3);
  endtask

  task automatic check_res(input string name, input longint m27, input longint v27,
                           input longint m28, input longint v28);
    chk({name, "_done"}, done, 1);
    chk({name, "_m27"}, $signed(mean_27), m27);
    chk({name, "_v27"}, var_27, v27);
    chk({name, "_m28"}, $signed(mean_28), m28);
    chk({name, "_v28"}, var_28, v28);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      start = 1; in_valid = 1;
      a27 = W'($urandom); a28 = W'($urandom); x27 = W'($urandom); x28 = W'($urandom);
      @(negedge clk);
      chk_en = 1;
    end
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", sample_cnt, 0);
    chk("rst_mean", $signed(mean_27) | $signed(mean_28), 0);
    chk("rst_var", var_27 | var_28, 0);
    rst_n = 1; start = 0; in_valid = 0;
    @(negedge clk);
    pulse_start();
    send(100, 100, -7, -7);
    send(0, 0, 0, 0);
    send(-300, -300, 5, 5);
    send(32767, 32767, -32768, -32768);
    wait_done("zero");
    check_res("zero", 0, 0, 0, 0);
    pulse_start();
    send(1, 0, 2, 0);
    send(11, 10, -2, 0);
    send(0, -1, 5, 3);
    send(-4, -5, 0, 2);
    wait_done("known");
    check_res("known", 1, 0, 0, 4);
    pulse_start();
    send(0, 1, 9, 9);
    send(0, 2, 9, 9);
    send(0, 3, 9, 9);
    send(0, 4, 9, 9);
    wait_done("floor");
    check_res("floor", -3, 0, 0, 0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      start = (i == 1);
      send(32767, -32768, 0, 0);
      start = 0;
      chk("hs_cnt", sample_cnt, i + 1);
      @(negedge clk);
    end
    while (!done && m_post != 0) @(negedge clk);
    chk("ext_done", done, 1);
    chk("ext_m27", $signed(mean_27), 65535);
    chk("ext_v27", var_27, 0);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("done_start_ignored", busy, 0);
    @(negedge clk);
    pulse_start();
    send(3, 0, 0, 0);
    send(3, 0, 0, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("mid_rst_cnt", sample_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mean", $signed(mean_27), 0);
    pulse_start();
    send(3, 0, 0, 0);
    send(5, 0, 0, 0);
    send(-1, 0, 0, 0);
    send(1, 0, 4, 0);
    wait_done("fresh");
    check_res("fresh", 2, 5, 1, 3);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
